// File: rtl/cpu_timer_irq.sv
// cpu_timer_irq: memory-mapped 16-bit countdown timer with IRQ.
// Synchronous read port (data one cycle after address), 65C02 bus.
module cpu_timer_irq #(
  parameter logic [15:0] BASE = 16'hFE00,
  parameter logic [7:0]  ID   = 8'hC7
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  output logic [7:0]  RD,
  output logic        rd_sel,
  output logic        IRQ
);

  localparam logic [2:0] OFF_CNT_L = 3'd0;
  localparam logic [2:0] OFF_CNT_H = 3'd1;
  localparam logic [2:0] OFF_LAT_L = 3'd2;
  localparam logic [2:0] OFF_LAT_H = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;
  localparam logic [2:0] OFF_STAT  = 3'd5;
  localparam logic [2:0] OFF_PRESC = 3'd6;
  localparam logic [2:0] OFF_ID    = 3'd7;

  logic        sel;
  logic        wr;
  logic        rd;
  logic [2:0]  off;

  logic [15:0] cnt;
  logic [15:0] lat;
  logic [2:0]  ctrl;
  logic        irq_flag;
  logic [7:0]  presc;
  logic [7:0]  pcnt;
  logic [7:0]  hold;

  logic        wr_lat_lo;
  logic        wr_lat_hi;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_presc;
  logic        load;
  logic        tick;
  logic        unf;
  logic [7:0]  rdata;

  logic        en;
  logic        cont;
  logic        ie;

  assign en   = ctrl[0];
  assign cont = ctrl[1];
  assign ie   = ctrl[2];

  assign off = AD[2:0];
  assign sel = (AD[15:3] == BASE[15:3]) & RDY;
  assign wr  = sel & WE;
  assign rd  = sel & ~WE;

  assign wr_lat_lo = wr & ((off == OFF_CNT_L) | (off == OFF_LAT_L));
  assign wr_lat_hi = wr & ((off == OFF_CNT_H) | (off == OFF_LAT_H));
  assign wr_ctrl   = wr & (off == OFF_CTRL);
  assign wr_stat   = wr & (off == OFF_STAT);
  assign wr_presc  = wr & (off == OFF_PRESC);

  // A counter load takes priority over any tick in the same cycle.
  assign load = wr & (off == OFF_CNT_H);
  assign tick = en & (pcnt == presc) & ~load;
  assign unf  = tick & (cnt == 16'h0000);

  assign IRQ = irq_flag & ie;

  // Prescaler: divides the clock by PRESC+1 while enabled.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pcnt <= 8'h00;
    end else if (load) begin
      pcnt <= 8'h00;
    end else if (en) begin
      if (pcnt == presc) pcnt <= 8'h00;
      else               pcnt <= pcnt + 8'h01;
    end else begin
      pcnt <= 8'h00;
    end
  end

  // Main down-counter: load, decrement, reload or stop at zero.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= 16'hFFFF;
    end else if (load) begin
      cnt <= {DO, lat[7:0]};
    end else if (tick) begin
      if (cnt != 16'h0000) cnt <= cnt - 16'h0001;
      else if (cont)       cnt <= lat;
      else                 cnt <= 16'h0000;
    end
  end

  // Reload latch; an underflow reload above sees the old value.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      lat <= 16'hFFFF;
    end else begin
      if (wr_lat_lo) lat[7:0]  <= DO;
      if (wr_lat_hi) lat[15:8] <= DO;
    end
  end

  // Control: explicit write beats load-enable and one-shot stop.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      ctrl <= 3'b000;
    end else if (wr_ctrl) begin
      ctrl <= DO[2:0];
    end else if (load) begin
      ctrl[0] <= 1'b1;
    end else if (unf && !cont) begin
      ctrl[0] <= 1'b0;
    end
  end

  // Interrupt flag: underflow set beats any clear.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      irq_flag <= 1'b0;
    end else if (unf) begin
      irq_flag <= 1'b1;
    end else if (load) begin
      irq_flag <= 1'b0;
    end else if (wr_stat && DO[0]) begin
      irq_flag <= 1'b0;
    end
  end

  // Prescaler reload value.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      presc <= 8'h00;
    end else if (wr_presc) begin
      presc <= DO;
    end
  end

  // Register read mux.
  always_comb begin
    rdata = 8'h00;
    unique case (off)
      OFF_CNT_L: rdata = cnt[7:0];
      OFF_CNT_H: rdata = hold;
      OFF_LAT_L: rdata = lat[7:0];
      OFF_LAT_H: rdata = lat[15:8];
      OFF_CTRL:  rdata = {5'b00000, ctrl};
      OFF_STAT:  rdata = {7'b0000000, irq_flag};
      OFF_PRESC: rdata = presc;
      OFF_ID:    rdata = ID;
      default:   rdata = 8'h00;
    endcase
  end

  // Registered read port; low-byte read snapshots the high byte.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      RD     <= 8'h00;
      rd_sel <= 1'b0;
      hold   <= 8'h00;
    end else if (rd) begin
      RD     <= rdata;
      rd_sel <= 1'b1;
      if (off == OFF_CNT_L) hold <= cnt[15:8];
    end else if (RDY) begin
      rd_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_timer_irq.sv
// tb_cpu_timer_irq: table-driven register checks plus
// hand-written timing sequences for the countdown timer.
module tb_cpu_timer_irq;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk;
  logic        RST_n;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic [7:0]  RD;
  logic        rd_sel;
  logic        IRQ;

  int nchk;
  int nerr;

  cpu_timer_irq #(.BASE(BASE), .ID(8'hC7)) dut (
    .clk    (clk),
    .RST_n  (RST_n),
    .AD     (AD),
    .DO     (DO),
    .WE     (WE),
    .RDY    (RDY),
    .RD     (RD),
    .rd_sel (rd_sel),
    .IRQ    (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] off;
    logic       we;
    logic       rdy;
    logic [7:0] wdata;
    logic       exp_sel;
    logic [7:0] exp_rd;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic chk8(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act,
                      input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic go_idle();
    AD  = 16'h0000;
    WE  = 1'b0;
    DO  = 8'h00;
    RDY = 1'b1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    AD  = BASE | {13'd0, off};
    WE  = 1'b1;
    DO  = d;
    RDY = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
  endtask

  task automatic rdchk(input string name, input logic [2:0] off,
                       input logic [7:0] exp);
    AD  = BASE | {13'd0, off};
    WE  = 1'b0;
    RDY = 1'b1;
    @(posedge clk);
    #1;
    chk1({name, "_sel"}, rd_sel, 1'b1);
    chk8(name, RD, exp);
    go_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_table();
    tbl[0]  = '{3'd7, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC7};
    tbl[1]  = '{3'd0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF};
    tbl[2]  = '{3'd1, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF};
    tbl[3]  = '{3'd4, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{3'd2, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF};
    tbl[6]  = '{3'd6, 1'b1, 1'b1, 8'h5A, 1'b0, 8'hFF};
    tbl[7]  = '{3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF};
    tbl[8]  = '{3'd6, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A};
    tbl[9]  = '{3'd4, 1'b1, 1'b1, 8'hFC, 1'b0, 8'h5A};
    tbl[10] = '{3'd4, 1'b0, 1'b1, 8'h00, 1'b1, 8'h04};
    tbl[11] = '{3'd2, 1'b1, 1'b1, 8'h34, 1'b0, 8'h04};
    tbl[12] = '{3'd3, 1'b1, 1'b1, 8'h12, 1'b0, 8'h04};
    tbl[13] = '{3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'h34};
    tbl[14] = '{3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h12};
    tbl[15] = '{3'd0, 1'b1, 1'b1, 8'h78, 1'b0, 8'h12};
    tbl[16] = '{3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'h78};
    tbl[17] = '{3'd5, 1'b1, 1'b1, 8'h01, 1'b0, 8'h78};
    tbl[18] = '{3'd5, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[19] = '{3'd7, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[20] = '{3'd7, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC7};
    tbl[21] = '{3'd4, 1'b1, 1'b1, 8'h00, 1'b0, 8'hC7};
    tbl[22] = '{3'd6, 1'b1, 1'b1, 8'h00, 1'b0, 8'hC7};
    tbl[23] = '{3'd6, 1'b1, 1'b0, 8'h33, 1'b0, 8'hC7};
    tbl[24] = '{3'd6, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    RST_n = 1'b0;
    go_idle();
    fill_table();

    #2;
    chk8("reset_rd", RD, 8'h00);
    chk1("reset_sel", rd_sel, 1'b0);
    chk1("reset_irq", IRQ, 1'b0);
    @(posedge clk);
    #1;
    RST_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      AD  = BASE | {13'd0, tbl[i].off};
      WE  = tbl[i].we;
      DO  = tbl[i].wdata;
      RDY = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d_sel", i), rd_sel, tbl[i].exp_sel);
      chk8($sformatf("vec%0d_rd", i), RD, tbl[i].exp_rd);
      go_idle();
    end

    wr(3'd4, 8'h04);
    wr(3'd0, 8'h03);
    wr(3'd1, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("oneshot_irq_c%0d", k), IRQ, k == 4);
    end
    rdchk("oneshot_ctrl", 3'd4, 8'h04);
    rdchk("oneshot_cnt_l", 3'd0, 8'h00);
    rdchk("oneshot_cnt_h", 3'd1, 8'h00);
    rdchk("oneshot_stat", 3'd5, 8'h01);
    wr(3'd5, 8'h01);
    chk1("oneshot_clr_irq", IRQ, 1'b0);

    wr(3'd6, 8'h01);
    wr(3'd4, 8'h06);
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("cont_irq_c%0d", k), IRQ, k == 6);
    end
    wr(3'd5, 8'h01);
    chk1("cont_clr_irq", IRQ, 1'b0);
    for (int k = 8; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("cont_irq_c%0d", k), IRQ, k == 12);
    end
    wr(3'd4, 8'h03);
    chk1("cont_ie0_irq", IRQ, 1'b0);
    rdchk("cont_ie0_stat", 3'd5, 8'h01);

    wr(3'd1, 8'h00);
    idle(5);
    wr(3'd5, 8'h01);
    rdchk("clr_vs_unf_stat", 3'd5, 8'h01);

    wr(3'd4, 8'h00);
    wr(3'd6, 8'h00);
    wr(3'd4, 8'h03);
    wr(3'd0, 8'h10);
    wr(3'd1, 8'h20);
    wr(3'd4, 8'h00);
    rdchk("load_vs_tick_l", 3'd0, 8'h0F);
    rdchk("load_vs_tick_h", 3'd1, 8'h20);

    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    rdchk("coh_a_l", 3'd0, 8'h00);
    rdchk("coh_a_h", 3'd1, 8'h01);
    rdchk("coh_b_l", 3'd0, 8'hFE);
    rdchk("coh_b_h", 3'd1, 8'h00);

    wr(3'd4, 8'h07);
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h00);
    chk1("rst_pre_irq0", IRQ, 1'b0);
    idle(2);
    chk1("rst_pre_irq1", IRQ, 1'b1);
    rdchk("rst_pre_id", 3'd7, 8'hC7);
    #2;
    RST_n = 1'b0;
    #1;
    chk1("rst_async_irq", IRQ, 1'b0);
    chk1("rst_async_sel", rd_sel, 1'b0);
    chk8("rst_async_rd", RD, 8'h00);
    @(negedge clk);
    RST_n = 1'b1;
    @(posedge clk);
    #1;
    rdchk("rst_cnt_l", 3'd0, 8'hFF);
    rdchk("rst_cnt_h", 3'd1, 8'hFF);
    rdchk("rst_ctrl", 3'd4, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule
